// File: rtl/onehot_idx_rr_if.sv
// -----------------------------------------------------------------------------
// onehot_idx_rr_if
// Request / grant bundle for the round-robin index encoder. Signal names are
// seen from the arbiter's side: i_* flow into the arbiter, o_* flow out.
//
//   i_req   [WIDTH]     request vector from the sources
//   i_ready             consumer accepts the presented grant
//   o_valid             a grant is pending on o_index/o_grant
//   o_index [ABSWIDTH]  binary index of the granted request
//   o_grant [WIDTH]     one-hot of o_index while o_valid, else zero
//   i_lock              present only when ONEHOT_IDX_RR_LOCK_EN is defined
//
// Modports: slave = arbiter, master = request source / grant consumer.
// -----------------------------------------------------------------------------
interface onehot_idx_rr_if #(
  parameter int WIDTH = 16
);
  localparam int ABSWIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-1:0]    i_req;
  logic                i_ready;
  logic                o_valid;
  logic [ABSWIDTH-1:0] o_index;
  logic [WIDTH-1:0]    o_grant;
`ifdef ONEHOT_IDX_RR_LOCK_EN
  logic                i_lock;

  modport slave  (input  i_req, i_ready, i_lock, output o_valid, o_index, o_grant);
  modport master (output i_req, i_ready, i_lock, input  o_valid, o_index, o_grant);
`else
  modport slave  (input  i_req, i_ready, output o_valid, o_index, o_grant);
  modport master (output i_req, i_ready, input  o_valid, o_index, o_grant);
`endif
endinterface

// File: rtl/onehot_idx_rr.sv
// -----------------------------------------------------------------------------
// onehot_idx_rr
// Round-robin first-set index encoder with a registered valid/ready output.
// Each load picks the first set bit of i_req at or above a rotating start
// point, wrapping past the top, and registers it as binary index and one-hot
// grant. A presented grant is held stable until accepted.
//
// Ports:
//   i_clk   clock, all state on the rising edge
//   i_rstn  asynchronous active-low reset
//   bus     onehot_idx_rr_if.slave (i_req, i_ready, o_valid, o_index,
//           o_grant, and i_lock when enabled)
//
// Parameter: WIDTH (>= 1, need not be a power of two). The interface
// instance must use the same WIDTH.
//
// Optional feature macro: ONEHOT_IDX_RR_LOCK_EN
//   Adds i_lock. Accepting with i_lock=1 keeps the accepted requester at top
//   priority instead of advancing past it.
// -----------------------------------------------------------------------------
module onehot_idx_rr #(
  parameter int WIDTH = 16
) (
  input  logic          i_clk,
  input  logic          i_rstn,
  onehot_idx_rr_if.slave bus
);

  localparam int                  ABSWIDTH = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [ABSWIDTH-1:0] LAST_IDX = ABSWIDTH'(WIDTH - 1);

  // state
  logic                r_valid;
  logic [ABSWIDTH-1:0] r_index;
  logic [WIDTH-1:0]    r_grant;
  logic [ABSWIDTH-1:0] r_ptr;

  // handshake / search
  logic                w_accept;
  logic                w_load;
  logic [ABSWIDTH-1:0] w_next_slot;
  logic [ABSWIDTH-1:0] w_start;
  logic [WIDTH-1:0]    w_hi_mask;
  logic [WIDTH-1:0]    w_req_hi;
  logic                w_hi_found;
  logic [ABSWIDTH-1:0] w_hi_idx;
  logic [ABSWIDTH-1:0] w_lo_idx;
  logic [ABSWIDTH-1:0] w_sel_idx;
  logic                w_any;
  logic [WIDTH-1:0]    w_sel_grant;

  assign w_accept = r_valid & bus.i_ready;
  assign w_load   = ~r_valid | bus.i_ready;

  // Slot after the presented index, wrapping at WIDTH rather than at a
  // power of two.
  assign w_next_slot = (r_index == LAST_IDX) ? '0 : r_index + 1'b1;

  // The pointer update of an accept is forwarded into the same cycle's search
  // so back-to-back grants rotate without a bubble or a repeat.
`ifdef ONEHOT_IDX_RR_LOCK_EN
  assign w_start = w_accept ? (bus.i_lock ? r_index : w_next_slot) : r_ptr;
`else
  assign w_start = w_accept ? w_next_slot : r_ptr;
`endif

  // Requests at or above the start point get first pick.
  always_comb begin
    w_hi_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_hi_mask[i] = (ABSWIDTH'(i) >= w_start);
    end
  end

  assign w_req_hi = bus.i_req & w_hi_mask;
  assign w_any    = |bus.i_req;

  // Two lowest-set-bit encoders: one on the upper (masked) slice, one on the
  // full vector to cover the wrap-around case.
  always_comb begin
    w_hi_found = 1'b0;
    w_hi_idx   = '0;
    w_lo_idx   = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (w_req_hi[i] && !w_hi_found) begin
        w_hi_found = 1'b1;
        w_hi_idx   = ABSWIDTH'(i);
      end
    end
    for (int unsigned i = WIDTH; i > 0; i--) begin
      if (bus.i_req[i-1]) begin
        w_lo_idx = ABSWIDTH'(i - 1);
      end
    end
  end

  assign w_sel_idx = w_hi_found ? w_hi_idx : w_lo_idx;

  always_comb begin
    w_sel_grant = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      w_sel_grant[i] = w_any && (w_sel_idx == ABSWIDTH'(i));
    end
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_valid <= 1'b0;
      r_index <= '0;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      if (w_load) begin
        r_valid <= w_any;
        r_index <= w_any ? w_sel_idx : '0;
        r_grant <= w_sel_grant;
      end
      if (w_accept) begin
        r_ptr <= w_start;
      end
    end
  end

  assign bus.o_valid = r_valid;
  assign bus.o_index = r_index;
  assign bus.o_grant = r_grant;

endmodule

// File: tb/tb_onehot_idx_rr.sv
module tb_onehot_idx_rr;

  logic clk    = 1'b0;
  logic rstn_a = 1'b1;
  logic rstn_b = 1'b1;

  always #5 clk = ~clk;

  onehot_idx_rr_if #(.WIDTH(16)) a_if ();
  onehot_idx_rr_if #(.WIDTH(9))  b_if ();

  onehot_idx_rr #(.WIDTH(16)) u_a (.i_clk(clk), .i_rstn(rstn_a), .bus(a_if.slave));
  onehot_idx_rr #(.WIDTH(9))  u_b (.i_clk(clk), .i_rstn(rstn_b), .bus(b_if.slave));

  int n_checks = 0;
  int n_fail   = 0;

  int qa[$];
  int qb[$];

  // reference model state: pending flag, pending index, pointer
  bit mva = 0; int mia = 0; int mpa = 0;
  bit mvb = 0; int mib = 0; int mpb = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock of the arbiter described directly from its rules: search the
  // ring starting at 'start' with modulo arithmetic.
  task automatic model_step(input int w, input logic [15:0] req, input bit rdy, input bit lk,
                            inout bit mv, inout int mi, inout int mp, output bit push);
    bit acc;
    bit load;
    int start;
    acc   = mv && rdy;
    load  = !mv || rdy;
    start = mp;
    if (acc) begin
      start = lk ? mi : (mi + 1) % w;
      mp    = start;
    end
    push = 0;
    if (load) begin
      mv = 0;
      mi = 0;
      for (int k = 0; k < w; k++) begin
        int j;
        j = (start + k) % w;
        if (req[j]) begin
          mv = 1;
          mi = j;
          break;
        end
      end
      push = mv;
    end
  endtask

  function automatic bit rand_lock();
`ifdef ONEHOT_IDX_RR_LOCK_EN
    return ($urandom_range(0, 3) == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [15:0] rand_req();
    logic [15:0] r;
    case ($urandom_range(0, 3))
      0: r = 16'($urandom) & 16'($urandom);
      1: r = 16'(1) << $urandom_range(0, 15);
      2: r = '0;
      default: r = 16'($urandom);
    endcase
    return r;
  endfunction

  // Drive inputs for the next edge, advance the model, wait past that edge.
  task automatic step_a(input logic [15:0] req, input bit rdy, input bit lk);
    bit push;
    a_if.i_req   = req;
    a_if.i_ready = rdy;
`ifdef ONEHOT_IDX_RR_LOCK_EN
    a_if.i_lock  = lk;
`endif
    model_step(16, req, rdy, lk, mva, mia, mpa, push);
    if (push) qa.push_back(mia);
    @(posedge clk);
    #2;
  endtask

  task automatic step_b(input logic [8:0] req, input bit rdy, input bit lk);
    bit push;
    b_if.i_req   = req;
    b_if.i_ready = rdy;
`ifdef ONEHOT_IDX_RR_LOCK_EN
    b_if.i_lock  = lk;
`endif
    model_step(9, {7'b0, req}, rdy, lk, mvb, mib, mpb, push);
    if (push) qb.push_back(mib);
    @(posedge clk);
    #2;
  endtask

  // Monitors: an accept is visible at the negedge as o_valid & i_ready.
  always @(negedge clk) begin
    if (rstn_a) begin
      if (a_if.o_valid) begin
        if (a_if.i_ready) begin
          if (qa.size() == 0) begin
            chk("a_sb_underflow", 32'(qa.size()), 1);
          end else begin
            int e;
            e = qa.pop_front();
            chk("a_index", 32'(a_if.o_index), 32'(e));
            chk("a_grant", 32'(a_if.o_grant), 32'(1) << e);
          end
        end
      end else begin
        chk("a_idle_index", 32'(a_if.o_index), 0);
        chk("a_idle_grant", 32'(a_if.o_grant), 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rstn_b) begin
      if (b_if.o_valid) begin
        if (b_if.i_ready) begin
          if (qb.size() == 0) begin
            chk("b_sb_underflow", 32'(qb.size()), 1);
          end else begin
            int e;
            e = qb.pop_front();
            chk("b_index", 32'(b_if.o_index), 32'(e));
            chk("b_grant", 32'(b_if.o_grant), 32'(1) << e);
          end
        end
      end else begin
        chk("b_idle_index", 32'(b_if.o_index), 0);
        chk("b_idle_grant", 32'(b_if.o_grant), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_if.i_req = '1; a_if.i_ready = 1'b1;
    b_if.i_req = '0; b_if.i_ready = 1'b0;
`ifdef ONEHOT_IDX_RR_LOCK_EN
    a_if.i_lock = 1'b0;
    b_if.i_lock = 1'b0;
`endif
    #1;
    rstn_a = 1'b0;
    rstn_b = 1'b0;
    #1;
    chk("reset_valid", 32'(a_if.o_valid), 0);
    chk("reset_index", 32'(a_if.o_index), 0);
    chk("reset_grant", 32'(a_if.o_grant), 0);
    @(posedge clk);
    @(posedge clk);
    #2;
    rstn_a = 1'b1;

    // rotation with all requests asserted
    for (int i = 0; i < 20; i++) step_a(16'hFFFF, 1'b1, 1'b0);

    // backpressure: hold index 5 while requests change
    step_a(16'h0020, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step_a(16'h0001, 1'b0, 1'b0);
      chk("bp_hold_index", 32'(a_if.o_index), 5);
      chk("bp_hold_grant", 32'(a_if.o_grant), 32'h0020);
    end
    step_a(16'h0001, 1'b1, 1'b0);
    step_a(16'hFFFF, 1'b1, 1'b0);

    // accept with no requests still advances the pointer
    step_a(16'h0020, 1'b1, 1'b0);
    step_a(16'h0000, 1'b1, 1'b0);
    step_a(16'hFFFF, 1'b1, 1'b0);
    step_a(16'hFFFF, 1'b1, 1'b0);

`ifdef ONEHOT_IDX_RR_LOCK_EN
    step_a(16'h0008, 1'b1, 1'b0);
    step_a(16'hFFFF, 1'b1, 1'b1);
    step_a(16'hFFFF, 1'b1, 1'b0);
    step_a(16'hFFFF, 1'b1, 1'b0);
`endif

    // randomized traffic with random backpressure
    for (int i = 0; i < 300; i++) begin
      step_a(rand_req(), ($urandom_range(0, 3) != 0), rand_lock());
    end

    // mid-stream reset while index 7 is held
    step_a(16'h0080, 1'b1, 1'b0);
    step_a(16'hFFFF, 1'b0, 1'b0);
    step_a(16'hFFFF, 1'b0, 1'b0);
    chk("pre_reset_index", 32'(a_if.o_index), 7);
    #2;
    rstn_a = 1'b0;
    #1;
    chk("midrst_valid", 32'(a_if.o_valid), 0);
    chk("midrst_index", 32'(a_if.o_index), 0);
    chk("midrst_grant", 32'(a_if.o_grant), 0);
    qa.delete();
    mva = 0; mia = 0; mpa = 0;
    @(posedge clk);
    #2;
    rstn_a = 1'b1;
    for (int i = 0; i < 6; i++) step_a(16'hFFFF, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) step_a(16'h0000, 1'b1, 1'b0);
    chk("a_drained", 32'(qa.size()), 0);

    // WIDTH=9: wrap from 8 back to 0, never 9
    rstn_b = 1'b1;
    for (int i = 0; i < 8; i++) step_b(9'h101, 1'b1, 1'b0);
    step_b(9'h1FF, 1'b1, 1'b0);
    step_b(9'h1FF, 1'b1, 1'b0);
    for (int i = 0; i < 150; i++) begin
      step_b(9'(rand_req()), ($urandom_range(0, 3) != 0), rand_lock());
    end
    for (int i = 0; i < 4; i++) step_b(9'h000, 1'b1, 1'b0);
    chk("b_drained", 32'(qb.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/onehot_idx_rr.md
# onehot_idx_rr

Round-robin first-set index encoder with a registered, handshaked output. It is the sequential, fair successor to the one-hot index encoder. Each cycle it accepts an arbitrary request vector and picks the first set bit at or above a rotating priority pointer, wrapping around the top. It presents the result as both binary index and one-hot grant through a valid/ready output register. It sits between request sources and a single shared resource as a parametrised arbiter front-end.

## Interface

- WIDTH, 16, number of request lines; any value ≥ 1, including non-powers-of-2.
- ABSWIDTH (localparam), max($clog2(WIDTH), 1), width of index and pointer.

- i_clk  input  1  clock; all state on rising edge.
- i_rstn  input  1  reset, asynchronous assert, active-low.
- i_req  input  WIDTH  request vector; any number of bits may be set.
- i_ready  input  1  consumer accepts the presented grant this cycle.
- o_valid  output  1  o_index/o_grant hold a pending grant.
- o_index  output  ABSWIDTH  binary index of granted request.
- o_grant  output  WIDTH  one-hot of o_index when o_valid, else all-zero.
- i_lock  input  1  present only with ONEHOT_IDX_RR_LOCK_EN; see Configuration.

## Operation

- State:
  - output register (o_valid, o_index, o_grant);
  - priority pointer ptr[ABSWIDTH-1:0].
- Reset values: o_valid=0, o_index=0, o_grant=0, ptr=0.
- accept = o_valid & i_ready.
- load = ~o_valid | i_ready; the output register updates only when load=1.
- Effective start point: start = accept ? ((o_index==WIDTH-1) ? 0 : o_index+1) : ptr. The same-cycle pointer advance is forwarded, so back-to-back grants are fair.
- Search: first set bit of i_req at index ≥ start, else first set bit below start (wrap). Indices ≥ WIDTH do not exist and are never produced.
- On load:
  - o_valid <= |i_req.
  - o_index <= found index, or 0 if none.
  - o_grant <= 1<<found, or 0 if none.
- On accept: ptr <= start, i.e. the slot after the accepted index, modulo WIDTH (not power-of-2 wrap).
- Held grant: while o_valid & ~i_ready, all outputs are stable. Withdrawal of the granted i_req bit does not retract the grant.
- i_req=0 on load with accept: o_valid falls next cycle and ptr still advances.
- WIDTH=1: ptr is always 0; block degenerates to a registered valid/ready of i_req[0].

## Timing

- Latency: i_req sampled at edge N appears on outputs after edge N, i.e. one cycle.
- Throughput: one grant per cycle with i_ready held high.
- Asynchronous reset: outputs and ptr go to reset values immediately on i_rstn fall, mid-transaction included. A pending grant is dropped. The first load occurs at the first rising edge with i_rstn high.
- No combinational path from i_req or i_ready to any output.

## Configuration

- ONEHOT_IDX_RR_LOCK_EN defined:
  - adds port i_lock;
  - on accept with i_lock=1, start = o_index, and ptr <= o_index, so the accepted requester keeps top priority for multi-beat ownership;
  - with i_lock=0, behaviour is identical to the build without the macro.
- Undefined: no i_lock port; pointer always advances on accept.

## Test plan

- Reset: i_rstn=0, i_req=16'hFFFF, i_ready=1 -> o_valid=0, o_index=0, o_grant=0. After release, first edge gives o_valid=1, o_index=0, o_grant=16'h0001.
- Rotation, WIDTH=16: i_req=16'hFFFF, i_ready=1 continuously -> o_index 0,1,2,…,15,0,1 on consecutive cycles, with no repeats.
- Backpressure: grant index 5 pending, i_ready=0 for 4 cycles while i_req changes to 16'h0001 -> o_index stays 5 and o_grant stays 16'h0020. Then i_ready=1 -> next o_index=0, and ptr=6 after accept.
- Wrap, WIDTH=9: i_req=9'h101, i_ready=1 -> o_index alternates 0,8,0,8. After accepting 8, ptr=0, never 9.
- Mid-stream reset: drop i_rstn between edges while o_valid=1, o_index=7 -> outputs zero immediately. After release with i_req=16'hFFFF -> o_index=0.
- ONEHOT_IDX_RR_LOCK_EN: i_req=16'hFFFF, accept index 3 with i_lock=1 -> next o_index=3. Accept again with i_lock=0 -> next o_index=4.
